// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module seq_divider #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   input  logic             is_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned HW = 32;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_word;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;

   function automatic logic [WIDTH-1:0] f_ext32(input logic [HW-1:0] x, input logic sgn);
      return {{(WIDTH-HW){sgn & x[HW-1]}}, x};
   endfunction

   // Effective operands and special-case detection, evaluated at accept
   logic [WIDTH-1:0] w_a, w_b, w_a_abs, w_b_abs, w_min;
   logic             w_a_neg, w_b_neg, w_div0, w_ovf, w_accept;
   logic [CW-1:0]    w_n;

   always_comb begin
      w_a      = is_word ? f_ext32(dividend[HW-1:0], is_signed) : dividend;
      w_b      = is_word ? f_ext32(divisor[HW-1:0], is_signed) : divisor;
      w_a_neg  = is_signed & w_a[WIDTH-1];
      w_b_neg  = is_signed & w_b[WIDTH-1];
      w_a_abs  = w_a_neg ? WIDTH'(0) - w_a : w_a;
      w_b_abs  = w_b_neg ? WIDTH'(0) - w_b : w_b;
      w_min    = is_word ? {{(WIDTH-HW+1){1'b1}}, {(HW-1){1'b0}}}
                         : {1'b1, {(WIDTH-1){1'b0}}};
      w_div0   = (w_b == '0);
      w_ovf    = is_signed & (w_a == w_min) & (&w_b);
      w_n      = is_word ? CW'(HW) : CW'(WIDTH);
      w_accept = (r_state == S_IDLE) & in_valid & ~flush;
   end

   // Trial subtraction; a set shifted-out MSB means the shifted remainder exceeds any divisor
   logic [WIDTH:0]   w_sum;
   logic             w_nb, w_last;
   logic [WIDTH-1:0] w_rem_sh, w_rem_nxt, w_quo_nxt, w_q_neg, w_r_neg, w_q_fin, w_r_fin;

   always_comb begin
      w_rem_sh  = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
      w_sum     = {1'b0, w_rem_sh} + {1'b0, ~r_div} + (WIDTH+1)'(1);
      w_nb      = r_rem[WIDTH-1] | w_sum[WIDTH];
      w_rem_nxt = w_nb ? w_sum[WIDTH-1:0] : w_rem_sh;
      w_quo_nxt = {r_quo[WIDTH-2:0], w_nb};
      w_q_neg   = r_neg_q ? WIDTH'(0) - w_quo_nxt : w_quo_nxt;
      w_r_neg   = r_neg_r ? WIDTH'(0) - w_rem_nxt : w_rem_nxt;
      w_q_fin   = r_word ? f_ext32(w_q_neg[HW-1:0], 1'b1) : w_q_neg;
      w_r_fin   = r_word ? f_ext32(w_r_neg[HW-1:0], 1'b1) : w_r_neg;
      w_last    = (r_cnt == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = (w_div0 | w_ovf) ? S_DONE : S_CALC;
         S_CALC: begin
            if (flush)       w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: if (flush | out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: load at accept, iterate in CALC, publish the fixed-up result on the last step
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_word  <= 1'b0;
         r_q_out <= '0;
         r_r_out <= '0;
      end else if (w_accept) begin
         r_rem   <= '0;
         r_quo   <= is_word ? (w_a_abs << HW) : w_a_abs;
         r_div   <= w_b_abs;
         r_cnt   <= w_n;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_word  <= is_word;
         if (w_div0) begin
            r_q_out <= '1;
            r_r_out <= is_word ? f_ext32(w_a[HW-1:0], 1'b1) : w_a;
         end else if (w_ovf) begin
            r_q_out <= w_a;
            r_r_out <= '0;
         end
      end else if (r_state == S_CALC && !flush) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         r_cnt <= r_cnt - CW'(1);
         if (w_last) begin
            r_q_out <= w_q_fin;
            r_r_out <= w_r_fin;
         end
      end
   end

   assign quotient  = r_q_out;
   assign remainder = r_r_out;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge monitor
// pops and compares whenever out_valid rises and checks hold stability while it stays high.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        is_signed = 1'b0;
   logic        is_word = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] quotient;
   logic [63:0] remainder;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        prev_v = 1'b0;
   logic [63:0] cap_q, cap_r;

   seq_divider #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .is_signed(is_signed), .is_word(is_word),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compare on the rising edge of out_valid, then require stable outputs
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
               chk("in_ready_in_done", 64'(in_ready), 64'd0);
            end
            cap_q = quotient;
            cap_r = remainder;
         end else if (out_valid && prev_v) begin
            chk("quotient_stable", quotient, cap_q);
            chk("remainder_stable", remainder, cap_r);
         end
         prev_v = out_valid;
      end
   end

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic w, input logic push, input logic [63:0] eq,
                        input logic [63:0] er, input int elat);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("wait_in_ready_timeout", 64'(in_ready), 64'd1);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      is_word   = w;
      in_valid  = 1'b1;
      if (push) sb.push_back('{q: eq, r: er, lat: elat, acc: cyc});
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 64'hDEAD_BEEF_0BAD_F00D;
      divisor  = 64'h5;
      chk("in_ready_after_accept", 64'(in_ready), 64'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || out_valid) chk("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic run(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic w, input logic [63:0] eq, input logic [63:0] er,
                      input int elat);
      issue(a, b, s, w, 1'b1, eq, er, elat);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_quotient", quotient, 64'd0);
      chk("reset_remainder", remainder, 64'd0);

      // Basic unsigned, signed, word and special-case vectors
      run(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
      run(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
      run(64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
      run(64'h1234, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
      run(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
          64'h8000_0000_0000_0000, 64'd0, 1);
      run(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 1);
      run(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33);
      run(64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 33);

      // Backpressure: hold the result, offer a new op that must not be taken
      out_ready = 1'b0;
      issue(64'd50, 64'd5, 1'b0, 1'b0, 1'b1, 64'd10, 64'd0, 65);
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("hold_out_valid_seen", 64'(out_valid), 64'd1);
      dividend = 64'd8;
      divisor  = 64'd2;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("idle_quotient_held", quotient, 64'd10);

      // Flush in CALC discards the op; flush in IDLE blocks an accept
      issue(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 0);
      repeat (19) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (80) @(negedge clk);
      dividend = 64'd9;
      divisor  = 64'd0;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_idle_no_accept", 64'(in_ready), 64'd1);
      repeat (3) @(negedge clk);
      run(64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65);

      // Reset in the middle of an operation
      issue(64'd77, 64'd7, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_quotient", quotient, 64'd0);
      chk("midrst_remainder", remainder, 64'd0);
      repeat (80) @(negedge clk);
      run(64'd1000, 64'd3, 1'b1, 1'b0, 64'd333, 64'd1, 65);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
